// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Frame layout is SYNC, CMD, ADDR, DATA, CHK.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    ISSUE
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_BADCMD  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam int unsigned FRAME_LEN = 5;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter. It fires on the edge where the count would
// reach TIMEOUT_CLKS-1, i.e. TIMEOUT_CLKS-1 edges after the last clear.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CLKS);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 2);

  logic [W-1:0] count;

  // A clear in the same cycle suppresses expiry, so a byte at the terminal count wins.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from the UART receiver, validates them and
// hands accepted commands to the register fabric; bad frames are counted.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Cmd_Valid,
  input  logic       i_Cmd_Ready,
  output logic       o_Cmd_Wr,
  output logic [7:0] o_Cmd_Addr,
  output logic [7:0] o_Cmd_Data,
  output logic       o_Err_Pulse,
  output logic [1:0] o_Err_Code,
  output logic [7:0] o_Err_Count
);

  state_t     state;
  logic [7:0] sh_cmd;
  logic [7:0] sh_addr;
  logic [7:0] sh_data;
  logic       in_frame;
  logic       tmr_clear;
  logic       expire;
  logic       err_req;
  logic [1:0] err_sel;

  assign in_frame  = (state == GET_CMD) || (state == GET_ADDR) ||
                     (state == GET_DATA) || (state == GET_CHK);
  assign tmr_clear = i_RX_DV || !in_frame;

  uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk    (i_Clock),
    .rst_n  (i_Rst_L),
    .clear  (tmr_clear),
    .enable (in_frame),
    .expire (expire)
  );

  // Error detection; expire is never asserted together with i_RX_DV.
  always_comb begin
    err_req = 1'b0;
    err_sel = ERR_CHK;
    case (state)
      GET_CMD: if (i_RX_DV && i_RX_Byte != CMD_WR && i_RX_Byte != CMD_RD) begin
        err_req = 1'b1;
        err_sel = ERR_BADCMD;
      end
      GET_CHK: if (i_RX_DV && i_RX_Byte != frame_chk(sh_cmd, sh_addr, sh_data)) begin
        err_req = 1'b1;
        err_sel = ERR_CHK;
      end
      ISSUE: if (i_RX_DV) begin
        err_req = 1'b1;
        err_sel = ERR_OVERRUN;
      end
      default: ;
    endcase
    if (expire) begin
      err_req = 1'b1;
      err_sel = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      sh_cmd      <= '0;
      sh_addr     <= '0;
      sh_data     <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd_Wr    <= 1'b0;
      o_Cmd_Addr  <= '0;
      o_Cmd_Data  <= '0;
      o_Err_Pulse <= 1'b0;
      o_Err_Code  <= '0;
      o_Err_Count <= '0;
    end else begin
      o_Err_Pulse <= err_req;
      if (err_req) begin
        o_Err_Code <= err_sel;
        if (o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'd1;
      end

      case (state)
        IDLE: if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state <= GET_CMD;
        GET_CMD: begin
          if (i_RX_DV) begin
            sh_cmd <= i_RX_Byte;
            state  <= err_req ? IDLE : GET_ADDR;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        GET_ADDR: begin
          if (i_RX_DV) begin
            sh_addr <= i_RX_Byte;
            state   <= GET_DATA;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        GET_DATA: begin
          if (i_RX_DV) begin
            sh_data <= i_RX_Byte;
            state   <= GET_CHK;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        GET_CHK: begin
          if (i_RX_DV && !err_req) begin
            o_Cmd_Valid <= 1'b1;
            o_Cmd_Wr    <= (sh_cmd == CMD_WR);
            o_Cmd_Addr  <= sh_addr;
            o_Cmd_Data  <= sh_data;
            state       <= ISSUE;
          end else if (i_RX_DV || expire) begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (o_Cmd_Valid && i_Cmd_Ready) begin
            o_Cmd_Valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected commands and
// error pulses into queues, a negedge monitor pops and compares them.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int T_CLKS = 4340;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         first_cyc;
    int         hold;
  } cmd_exp_t;

  typedef struct {
    logic [1:0] code;
    logic [7:0] count;
    int         cyc;
  } err_exp_t;

  cmd_exp_t cmd_q[$];
  err_exp_t err_q[$];
  cmd_exp_t cur_cmd;
  err_exp_t cur_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;
  bit in_valid = 1'b0;
  int v_first = 0;
  int v_cycles = 0;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T_CLKS)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_Cmd_Valid (cmd_valid),
    .i_Cmd_Ready (cmd_ready),
    .o_Cmd_Wr    (cmd_wr),
    .o_Cmd_Addr  (cmd_addr),
    .o_Cmd_Data  (cmd_data),
    .o_Err_Pulse (err_pulse),
    .o_Err_Code  (err_code),
    .o_Err_Count (err_count)
  );

  always #5 clk = ~clk;

  // Cycle stamp: holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    checkOutput({tag, "_wr"}, 32'(cmd_wr), 32'd0);
    checkOutput({tag, "_addr"}, 32'(cmd_addr), 32'd0);
    checkOutput({tag, "_data"}, 32'(cmd_data), 32'd0);
    checkOutput({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    checkOutput({tag, "_code"}, 32'(err_code), 32'd0);
    checkOutput({tag, "_count"}, 32'(err_count), 32'd0);
  endtask

  // Drives one byte strobe from posedge+1; returns the edge that sampled it.
  task automatic applyStimulus(input logic [7:0] b, output int strobe_cyc);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    strobe_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectErr(input logic [1:0] code, input int at_cyc);
    exp_count = (exp_count == 255) ? 255 : exp_count + 1;
    err_q.push_back('{code: code, count: 8'(exp_count), cyc: at_cyc});
  endtask

  task automatic sendErrByte(input logic [7:0] b, input logic [1:0] code);
    int c;
    expectErr(code, cyc + 1);
    applyStimulus(b, c);
  endtask

  task automatic sendTail(input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] data, input int hold);
    int c;
    logic [7:0] chk;
    chk = cmd ^ addr ^ data;
    applyStimulus(addr, c);
    applyStimulus(data, c);
    cmd_q.push_back('{wr: (cmd == 8'h01), addr: addr, data: data, first_cyc: cyc + 1, hold: hold});
    applyStimulus(chk, c);
  endtask

  task automatic sendGood(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                          input int hold);
    int c;
    logic [7:0] cmd;
    cmd = wr ? 8'h01 : 8'h02;
    applyStimulus(8'hA5, c);
    applyStimulus(cmd, c);
    sendTail(cmd, addr, data, hold);
  endtask

  // Monitor: compares every error pulse and every valid command cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_err_pulse: got code %0d count %0d at cycle %0d, required none",
                   err_code, err_count, cyc);
        end else begin
          cur_err = err_q.pop_front();
          checkOutput("err_code", 32'(err_code), 32'(cur_err.code));
          checkOutput("err_count", 32'(err_count), 32'(cur_err.count));
          checkOutput("err_cycle", 32'(cyc), 32'(cur_err.cyc));
        end
      end
      if (cmd_valid) begin
        if (!in_valid) begin
          v_first  = cyc;
          v_cycles = 0;
        end
        in_valid = 1'b1;
        v_cycles++;
        if (cmd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_cmd_valid: got addr %0h at cycle %0d, required none",
                   cmd_addr, cyc);
        end else begin
          checkOutput("cmd_wr", 32'(cmd_wr), 32'(cmd_q[0].wr));
          checkOutput("cmd_addr", 32'(cmd_addr), 32'(cmd_q[0].addr));
          checkOutput("cmd_data", 32'(cmd_data), 32'(cmd_q[0].data));
          if (cmd_ready) begin
            cur_cmd = cmd_q.pop_front();
            checkOutput("cmd_first_cycle", 32'(v_first), 32'(cur_cmd.first_cyc));
            checkOutput("cmd_valid_cycles", 32'(v_cycles), 32'(cur_cmd.hold));
            in_valid = 1'b0;
          end
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  initial begin
    int c;
    logic [7:0] bad_frame [FRAME_LEN];
    bad_frame = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00};

    cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    idle(2);

    // Non-sync bytes in IDLE are ignored silently.
    applyStimulus(8'h00, c);
    applyStimulus(8'h3C, c);
    applyStimulus(8'hFF, c);
    idle(3);

    // Good write with ready already high.
    sendGood(1'b1, 8'h10, 8'h3C, 1);
    idle(2);

    // Good read held off by 50 cycles of backpressure.
    cmd_ready = 1'b0;
    sendGood(1'b0, 8'h20, 8'h00, 51);
    idle(50);
    cmd_ready = 1'b1;
    idle(3);

    // Bad checksum, then bad command immediately after.
    applyStimulus(8'hA5, c);
    applyStimulus(8'h01, c);
    applyStimulus(8'h10, c);
    applyStimulus(8'h3C, c);
    sendErrByte(8'h00, ERR_CHK);
    applyStimulus(8'hA5, c);
    sendErrByte(8'h07, ERR_BADCMD);
    idle(2);
    checkOutput("code_after_badcmd", 32'(err_code), 32'd1);
    checkOutput("count_after_badcmd", 32'(err_count), 32'd2);

    // Timeout after the CMD byte, then a good frame.
    applyStimulus(8'hA5, c);
    applyStimulus(8'h01, c);
    expectErr(ERR_TIMEOUT, c + T_CLKS - 1);
    idle(T_CLKS + 2);
    checkOutput("code_after_timeout", 32'(err_code), 32'd2);
    sendGood(1'b1, 8'h44, 8'h55, 1);
    idle(2);

    // Byte arriving on the terminal timeout count is accepted.
    applyStimulus(8'hA5, c);
    applyStimulus(8'h02, c);
    idle(T_CLKS - 2);
    sendTail(8'h02, 8'h12, 8'h34, 1);
    idle(2);

    // SYNC value inside a frame is ordinary data.
    sendGood(1'b1, 8'hA5, 8'hA5, 1);
    idle(2);

    // Overrun: three bytes while the command waits.
    cmd_ready = 1'b0;
    sendGood(1'b0, 8'h33, 8'h00, 6);
    sendErrByte(8'h11, ERR_OVERRUN);
    sendErrByte(8'h22, ERR_OVERRUN);
    sendErrByte(8'hA5, ERR_OVERRUN);
    idle(2);
    cmd_ready = 1'b1;
    idle(3);
    checkOutput("code_after_overrun", 32'(err_code), 32'd3);
    checkOutput("count_after_overrun", 32'(err_count), 32'd6);

    // Saturation with back-to-back bad-checksum frames.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < FRAME_LEN - 1; j++) applyStimulus(bad_frame[j], c);
      sendErrByte(bad_frame[FRAME_LEN-1], ERR_CHK);
    end
    idle(2);
    checkOutput("count_saturated", 32'(err_count), 32'd255);

    // Reset mid-frame drops everything without an error.
    applyStimulus(8'hA5, c);
    applyStimulus(8'h01, c);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    exp_count = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    sendGood(1'b0, 8'h7F, 8'h00, 1);
    idle(2);
    for (int j = 0; j < FRAME_LEN - 1; j++) applyStimulus(bad_frame[j], c);
    sendErrByte(bad_frame[FRAME_LEN-1], ERR_CHK);
    idle(10);
    checkOutput("count_after_reset", 32'(err_count), 32'd1);

    checkOutput("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    checkOutput("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame-level controller sitting directly behind the UART receiver. It consumes the receiver's byte-valid/byte stream, assembles fixed 5-byte command frames (sync, command, address, data, checksum), validates them, and presents accepted read/write commands to the register fabric over a valid/ready handshake. Malformed, stalled or overrunning frames are discarded and reported through an error pulse, an error code and a saturating error counter.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, default 4340: maximum clocks between bytes inside a frame, about 20 bit-times at 217 clocks/bit; must be ≥ 2.
- `i_Clock`, input, 1: single clock for all logic.
- `i_Rst_L`, input, 1: asynchronous, active-low reset.
- `i_RX_DV`, input, 1: one-cycle strobe from the UART receiver meaning a byte is valid.
- `i_RX_Byte`, input, 8: received byte, sampled only when `i_RX_DV`=1.
- `o_Cmd_Valid`, output, 1: command available; held until accepted.
- `i_Cmd_Ready`, input, 1: consumer accepts the command.
- `o_Cmd_Wr`, output, 1: 1 = write, 0 = read.
- `o_Cmd_Addr`, output, 8: register address.
- `o_Cmd_Data`, output, 8: write data; the value is don't-care-but-stable for reads.
- `o_Err_Pulse`, output, 1: one-cycle strobe when a frame is discarded.
- `o_Err_Code`, output, 2: cause of the last error, held until the next error. 0 = checksum, 1 = bad command, 2 = timeout, 3 = overrun.
- `o_Err_Count`, output, 8: count of discarded frames, saturating at 255.

## Operation
- **Frame format:** SYNC, CMD, ADDR, DATA, CHK, with CHK = CMD ^ ADDR ^ DATA.
- **Command codes:** CMD 8'h01 is a write and 8'h02 is a read. Any other value is a bad command.
- **States:** IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, ISSUE.
- **IDLE:**
  - A byte equal to SYNC_BYTE moves the FSM to GET_CMD.
  - Any other byte is silently ignored: no error, no count.
- **GET_CMD, GET_ADDR, GET_DATA:**
  - Each byte is latched into a shadow register and the FSM advances.
  - The CMD byte is validated at reception. A bad command raises error 1 and the FSM returns to IDLE.
  - A SYNC_BYTE value received mid-frame is ordinary data. There is no resync.
- **GET_CHK:**
  - Checksum match: the shadow registers are copied to the `o_Cmd_*` outputs and the FSM enters ISSUE.
  - Checksum mismatch: error 0, FSM returns to IDLE.
- **ISSUE:**
  - `o_Cmd_Valid`=1 and the outputs are stable.
  - When `o_Cmd_Valid` && `i_Cmd_Ready`, the command is accepted and the FSM returns to IDLE.
  - Any `i_RX_DV` while in ISSUE drops that byte and raises error 3. The FSM stays in ISSUE.
- **Timeout:**
  - An inter-byte counter runs only in the GET_* states.
  - It clears on entry to each GET_* state and on every `i_RX_DV`.
  - When it reaches TIMEOUT_CLKS−1 with no `i_RX_DV` that cycle, error 2 is raised and the FSM returns to IDLE.
  - ISSUE has no timeout.
- **Error reporting:** every error pulses `o_Err_Pulse`, updates `o_Err_Code` and increments `o_Err_Count` unless it is already 255.
- **Reset values:**
  - All outputs are 0.
  - FSM is in IDLE, and the shadow registers and timeout counter are 0.
  - Reset mid-frame or mid-ISSUE drops the frame with no error reported.

## Timing
- All outputs are registered.
- A byte strobed at edge t is acted on at edge t, and its effect is visible after t.
- CHK strobe at cycle t gives `o_Cmd_Valid`=1 from cycle t+1, so latency is one cycle from the last byte.
- If `i_Cmd_Ready` is already high at t+1, the handshake completes at t+1 and `o_Cmd_Valid` is 0 at t+2.
- Error pulse:
  - `o_Err_Pulse` is high for exactly the cycle after the offending byte or timeout.
  - `o_Err_Code` and `o_Err_Count` update in that same cycle.
- When `i_RX_DV` coincides with the terminal timeout count, the byte wins: it is accepted and the counter clears.
- A new SYNC byte may be accepted in the cycle immediately after the FSM returns to IDLE.
- Back-to-back frames with no idle gap are supported.

## Structure
- **Package `uart_cmd_pkg`:** holds the state enum, CMD_WR/CMD_RD constants, the ERR_CHK/ERR_BADCMD/ERR_TIMEOUT/ERR_OVERRUN codes and the frame length constant.
- **Sub-module `uart_cmd_timer`:** the inter-byte timeout counter.
  - Inputs: clear, enable.
  - Output: expire.
  - Counter width: $clog2(TIMEOUT_CLKS).
- Everything else, including the FSM, shadow registers, checksum and error logic, lives in the top level.

## Test plan
- **Good write:** bytes A5 01 10 3C 2D with `i_Cmd_Ready`=1 → one `o_Cmd_Valid` cycle with Wr=1, Addr=8'h10, Data=8'h3C; no error.
- **Good read with backpressure:** bytes A5 02 20 00 22 with Ready held 0 for 50 cycles → Valid stays 1 with stable outputs for 50 cycles, drops the cycle after Ready=1; Wr=0, Addr=8'h20.
- **Bad checksum, then bad command:**
  - A5 01 10 3C 00 → Err_Pulse, Code=0, Count=1, no Valid.
  - Then A5 07 → Code=1, Count=2.
- **Timeout:** A5 01 followed by silence for TIMEOUT_CLKS → Err_Pulse with Code=2 exactly TIMEOUT_CLKS−1 cycles after the CMD strobe. A following good frame is accepted.
- **Overrun:** good frame with Ready=0, then 3 extra bytes → three error pulses, Code=3, Count+3. The original command is still delivered intact after Ready=1.
- **Saturation and reset:**
  - 300 bad-checksum frames → Count=255.
  - Asserting `i_Rst_L`=0 mid-frame (after A5 01) → all outputs 0.
  - After release, a good frame decodes correctly.
